fetch_seq_ctrl: RTL and testbench
=================================

Name: fetch_seq_ctrl

Overview:
- Sequencing controller for the fetch stage.
- Decides each cycle whether the PC advances, holds, vectors to the exception handler, or returns to EPC.
- Drives the PC enable, PCtoIn, PCBack and D-register flush controls. Tracks the branch-delay-slot (BD) bit attached to every fetched instruction.
- Holds an eret in decode until every in-flight mtc0-to-EPC write has drained.

Parameters:
- BOOT_WAIT, 2, cycles after reset release before the first PC advance (IM warm-up).
- CNT_W, 4, width of the internal boot/wait counter. BOOT_WAIT must be < 2^CNT_W.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- exc_req  input  1  exception/interrupt committed in M stage
- eret_D  input  1  eret decoded in D stage
- mtEPC_D  input  1  mtc0 to EPC in D
- mtEPC_E  input  1  mtc0 to EPC in E
- mtEPC_M  input  1  mtc0 to EPC in M
- stall_req  input  1  data-hazard stall from hazard unit
- isBranch_D  input  1  instruction in D is branch/jump (next fetch is a delay slot)
- PCE  output  1  PC register enable
- PCtoIn  output  1  load handler vector next edge
- PCBack  output  1  load EPC next edge
- flush_D  output  1  clear F/D pipeline register
- isBranch  output  1  BD bit for the instruction currently fetched
- state_o  output  3  current FSM state (debug)
- stall_cnt  output  32  stall-cycle counter (optional feature)

Behaviour:
- States: BOOT=0, RUN=1, ERET_WAIT=2, ERET_GO=3, EXC=4.
- Reset values: state=BOOT, counter=0, PCE=0, PCtoIn=0, PCBack=0, flush_D=0, isBranch=0, stall_cnt=0.
- Reset asserted in any state returns to BOOT the next edge. It overrides all requests and aborts a pending eret.
- BOOT:
  - PCE=0.
  - Counter increments each cycle; when it reaches BOOT_WAIT-1, go to RUN.
  - With BOOT_WAIT=0, go directly to RUN one cycle after reset.
  - exc_req is ignored in BOOT.
- RUN, priority exc_req > eret_D > stall_req:
  - exc_req=1: go to EXC.
  - eret_D=1 and any mtEPC_* = 1: go to ERET_WAIT. PCE=0.
  - eret_D=1 and no mtEPC_*: go to ERET_GO. PCE=0.
  - stall_req=1: PCE=0, stay in RUN.
  - Otherwise PCE=1.
- EXC (exactly 1 cycle):
  - PCtoIn=1, PCE=1, flush_D=1, isBranch cleared.
  - Next state is RUN.
- ERET_WAIT:
  - PCE=0. Stays while mtEPC_D|mtEPC_E|mtEPC_M is set; then ERET_GO.
  - exc_req=1 here: go to EXC, eret abandoned.
- ERET_GO (exactly 1 cycle):
  - PCBack=1, PCE=1, flush_D=1 (eret has no delay slot).
  - Next state is RUN. exc_req in this cycle still wins: go to EXC, PCBack=0.
- Outputs PCE, PCtoIn, PCBack and flush_D are combinational from state and inputs.
- PCtoIn and PCBack are never both 1.
- isBranch:
  - Registered. On each edge with PCE=1 in RUN, isBranch <= isBranch_D.
  - Holds while PCE=0.
  - Cleared on EXC and ERET_GO.
- A stall_req arriving together with eret_D is subsumed: eret handling already holds the PC.

Optional Feature:
- Macro FETCH_STALL_CNT_EN.
- Defined:
  - stall_cnt is a 32-bit register, reset 0.
  - Increments by 1 on each edge where state ∈ {RUN, ERET_WAIT} and PCE=0.
  - Wraps 0xFFFF_FFFF to 0.
- Undefined: stall_cnt is tied to 0 and no counter logic is inferred.

Test Plan:
- Reset release with BOOT_WAIT=2 → PCE=0 for 2 cycles, PCE=1 on the 3rd; state_o goes 0,0,1.
- RUN, stall_req=1 for 3 cycles → PCE=0 for exactly those 3 cycles. With FETCH_STALL_CNT_EN, stall_cnt=3.
- eret_D=1 with mtEPC_E=1, then mtEPC_M=1 next cycle, then both 0 → ERET_WAIT for 2 cycles, then PCBack=1 and flush_D=1 for 1 cycle, then RUN with PCE=1.
- exc_req=1 in the same cycle as eret_D=1 and stall_req=1 → PCtoIn=1, PCBack=0, flush_D=1 for one cycle, then RUN.
- isBranch_D=1 while PCE=1 → isBranch=1 next cycle. A following stall holds isBranch=1. An exception clears it to 0.
- Reset asserted during ERET_WAIT → next cycle state=BOOT and all outputs at reset values. No PCBack pulse occurs.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencing controller: PC advance/hold/vector/return-to-EPC and BD-bit tracking.
// Latency: PCE/PCtoIn/PCBack/flush_D are combinational from state+inputs; isBranch and state update on the next edge.
// Backpressure: stall_req or an in-flight mtc0->EPC write holds the PC (PCE=0); exc_req pre-empts everything except BOOT.
// Optional macro FETCH_STALL_CNT_EN: enables the 32-bit stall-cycle counter on stall_cnt (tied to 0 otherwise).
// BOOT_WAIT must be smaller than 2**CNT_W so the boot counter can reach BOOT_WAIT-1.

module fetch_seq_ctrl #(
  parameter int BOOT_WAIT = 2,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic        eret_D,
  input  logic        mtEPC_D,
  input  logic        mtEPC_E,
  input  logic        mtEPC_M,
  input  logic        stall_req,
  input  logic        isBranch_D,
  output logic        PCE,
  output logic        PCtoIn,
  output logic        PCBack,
  output logic        flush_D,
  output logic        isBranch,
  output logic [2:0]  state_o,
  output logic [31:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_BOOT      = 3'd0,
    S_RUN       = 3'd1,
    S_ERET_WAIT = 3'd2,
    S_ERET_GO   = 3'd3,
    S_EXC       = 3'd4
  } state_t;

  // Last boot-counter value before the first PC advance; BOOT_WAIT=0 behaves like 1
  // (one BOOT cycle after reset, then RUN).
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'((BOOT_WAIT == 0) ? 0 : BOOT_WAIT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             is_branch_q;
  logic             is_branch_d;

  // Raw (pre-reset-gating) control decisions from the next-state logic.
  logic             pce_c;
  logic             to_in_c;
  logic             back_c;
  logic             flush_c;

  // Any mtc0 to EPC still travelling down the pipe makes EPC stale for an eret.
  logic             epc_busy;
  assign epc_busy = mtEPC_D | mtEPC_E | mtEPC_M;

  // State, boot counter and BD-bit registers; reset wins over every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_BOOT;
      cnt_q       <= '0;
      is_branch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_branch_q <= is_branch_d;
    end
  end

  // Next-state, PC controls and BD-bit update, priority exc_req > eret_D > stall_req.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pce_c       = 1'b0;
    to_in_c     = 1'b0;
    back_c      = 1'b0;
    flush_c     = 1'b0;
    is_branch_d = is_branch_q;
    case (state_q)
      S_BOOT: begin
        // IM warm-up: PC held, exceptions ignored until the counter expires.
        if (cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (exc_req) begin
          // PC held this cycle; the handler vector is loaded from EXC.
          state_d = S_EXC;
        end else if (eret_D) begin
          // A simultaneous stall_req is subsumed: the eret path already holds the PC.
          state_d = epc_busy ? S_ERET_WAIT : S_ERET_GO;
        end else if (stall_req) begin
          state_d = S_RUN;
        end else begin
          pce_c       = 1'b1;
          is_branch_d = isBranch_D;
        end
      end
      S_ERET_WAIT: begin
        if (exc_req) begin
          state_d = S_EXC;
        end else if (!epc_busy) begin
          state_d = S_ERET_GO;
        end
      end
      S_ERET_GO: begin
        // eret has no delay slot: flush D and clear the BD bit either way.
        flush_c     = 1'b1;
        is_branch_d = 1'b0;
        if (exc_req) begin
          state_d = S_EXC;
        end else begin
          pce_c   = 1'b1;
          back_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_EXC: begin
        pce_c       = 1'b1;
        to_in_c     = 1'b1;
        flush_c     = 1'b1;
        is_branch_d = 1'b0;
        state_d     = S_RUN;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Controls read as reset values while reset is held, whatever the current state.
  assign PCE      = pce_c   & ~reset;
  assign PCtoIn   = to_in_c & ~reset;
  assign PCBack   = back_c  & ~reset;
  assign flush_D  = flush_c & ~reset;
  assign isBranch = is_branch_q;
  assign state_o  = state_q;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count edges on which fetch is held in RUN or ERET_WAIT; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (((state_q == S_RUN) || (state_q == S_ERET_WAIT)) && !pce_c) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

  // Vector load and EPC return are mutually exclusive by construction.
  a_vec_ret_excl: assert property (@(posedge clk) disable iff (reset) !(PCtoIn && PCBack));

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
module tb_fetch_seq_ctrl;

  localparam int BOOT_WAIT = 2;
`ifdef FETCH_STALL_CNT_EN
  localparam int SC_ON = 1;
`else
  localparam int SC_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req, eret_D, mtEPC_D, mtEPC_E, mtEPC_M, stall_req, isBranch_D;
  logic        PCE, PCtoIn, PCBack, flush_D, isBranch;
  logic [2:0]  state_o;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  fetch_seq_ctrl #(.BOOT_WAIT(BOOT_WAIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .eret_D(eret_D),
    .mtEPC_D(mtEPC_D), .mtEPC_E(mtEPC_E), .mtEPC_M(mtEPC_M),
    .stall_req(stall_req), .isBranch_D(isBranch_D),
    .PCE(PCE), .PCtoIn(PCtoIn), .PCBack(PCBack), .flush_D(flush_D),
    .isBranch(isBranch), .state_o(state_o), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks "what kind of cycle is this" as flags rather than a state code.
  bit          m_boot = 1'b1;
  int          m_boot_cycles = 0;
  bit          m_exc_cyc = 1'b0;
  bit          m_go_cyc = 1'b0;
  bit          m_waiting = 1'b0;
  bit          m_isb = 1'b0;
  logic [31:0] m_sc = 32'd0;

  always @(negedge clk) begin : model
    logic e_pce, e_in, e_back, e_fl, busy, run_cyc;
    int   e_state;
    busy    = mtEPC_D | mtEPC_E | mtEPC_M;
    run_cyc = !m_boot && !m_exc_cyc && !m_go_cyc && !m_waiting;
    e_pce = 0; e_in = 0; e_back = 0; e_fl = 0;
    if (m_exc_cyc) begin
      e_pce = 1; e_in = 1; e_fl = 1;
    end else if (m_go_cyc) begin
      e_fl = 1;
      if (!exc_req) begin e_pce = 1; e_back = 1; end
    end else if (run_cyc) begin
      e_pce = !(exc_req || eret_D || stall_req);
    end
    e_state = m_boot ? 0 : m_exc_cyc ? 4 : m_go_cyc ? 3 : m_waiting ? 2 : 1;

    check("m_state", state_o, e_state);
    check("m_PCE", PCE, e_pce & ~reset);
    check("m_PCtoIn", PCtoIn, e_in & ~reset);
    check("m_PCBack", PCBack, e_back & ~reset);
    check("m_flush_D", flush_D, e_fl & ~reset);
    check("m_isBranch", isBranch, m_isb);
    check("m_stall_cnt", stall_cnt, (SC_ON != 0) ? m_sc : 32'd0);

    // advance the model across the coming rising edge
    if (reset) begin
      m_boot = 1; m_boot_cycles = 0; m_exc_cyc = 0; m_go_cyc = 0; m_waiting = 0;
      m_isb = 0; m_sc = 0;
    end else begin
      if ((run_cyc || m_waiting) && !e_pce) m_sc = m_sc + 32'd1;
      if (m_exc_cyc || m_go_cyc) m_isb = 0;
      else if (run_cyc && e_pce) m_isb = isBranch_D;
      if (m_boot) begin
        m_boot_cycles = m_boot_cycles + 1;
        if (m_boot_cycles >= BOOT_WAIT) m_boot = 0;
      end else if (m_exc_cyc) begin
        m_exc_cyc = 0;
      end else if (m_go_cyc) begin
        m_go_cyc = 0;
        m_exc_cyc = exc_req;
      end else if (m_waiting) begin
        if (exc_req) begin m_waiting = 0; m_exc_cyc = 1; end
        else if (!busy) begin m_waiting = 0; m_go_cyc = 1; end
      end else begin
        if (exc_req) m_exc_cyc = 1;
        else if (eret_D) begin
          if (busy) m_waiting = 1; else m_go_cyc = 1;
        end
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic nxt();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #2;
  endtask

  initial begin
    reset = 1; exc_req = 0; eret_D = 0; mtEPC_D = 0; mtEPC_E = 0; mtEPC_M = 0;
    stall_req = 0; isBranch_D = 0;
    repeat (2) @(posedge clk);
    #1;
    mid();
    check("rst state", state_o, 0);
    check("rst PCE", PCE, 0);
    check("rst PCtoIn", PCtoIn, 0);
    check("rst PCBack", PCBack, 0);
    check("rst flush_D", flush_D, 0);
    check("rst isBranch", isBranch, 0);
    check("rst stall_cnt", stall_cnt, 0);

    // boot sequence: state 0,0,1 and PCE 0,0,1
    nxt(); reset = 0;
    mid(); check("boot1 state", state_o, 0); check("boot1 PCE", PCE, 0);
    nxt();
    mid(); check("boot2 state", state_o, 0); check("boot2 PCE", PCE, 0);
    nxt();
    mid(); check("boot3 state", state_o, 1); check("boot3 PCE", PCE, 1);

    // three-cycle data stall
    for (int i = 0; i < 3; i++) begin
      nxt(); stall_req = 1;
      mid(); check("stall PCE", PCE, 0);
    end
    nxt(); stall_req = 0; isBranch_D = 1;
    mid(); check("post-stall PCE", PCE, 1);
    check("stall_cnt 3", stall_cnt, (SC_ON != 0) ? 32'd3 : 32'd0);
    check("bd not yet", isBranch, 0);

    // BD bit captured, held across stall, cleared by exception
    nxt(); isBranch_D = 0; stall_req = 1;
    mid(); check("bd captured", isBranch, 1); check("bd stall PCE", PCE, 0);
    nxt();
    mid(); check("bd held", isBranch, 1);
    nxt(); stall_req = 0; exc_req = 1;
    mid(); check("exc req state", state_o, 1);
    nxt(); exc_req = 0;
    mid(); check("exc state", state_o, 4); check("exc PCtoIn", PCtoIn, 1);
    check("exc flush", flush_D, 1); check("exc PCBack", PCBack, 0);
    nxt();
    mid(); check("after exc state", state_o, 1); check("bd cleared", isBranch, 0);
    check("after exc PCE", PCE, 1);

    // exc + eret + stall in the same cycle
    nxt(); exc_req = 1; eret_D = 1; stall_req = 1;
    mid(); check("combo PCE", PCE, 0);
    nxt(); exc_req = 0; eret_D = 0; stall_req = 0;
    mid(); check("combo state", state_o, 4); check("combo PCtoIn", PCtoIn, 1);
    check("combo PCBack", PCBack, 0); check("combo flush", flush_D, 1);
    nxt();
    mid(); check("combo run", state_o, 1); check("combo run PCE", PCE, 1);

    // eret waits for mtc0->EPC in E then M
    nxt(); eret_D = 1; mtEPC_E = 1;
    mid(); check("eret PCE", PCE, 0);
    nxt(); mtEPC_E = 0; mtEPC_M = 1;
    mid(); check("wait1 state", state_o, 2); check("wait1 PCE", PCE, 0);
    nxt(); mtEPC_M = 0;
    mid(); check("wait2 state", state_o, 2);
    nxt(); eret_D = 0;
    mid(); check("go state", state_o, 3); check("go PCBack", PCBack, 1);
    check("go flush", flush_D, 1); check("go PCE", PCE, 1); check("go PCtoIn", PCtoIn, 0);
    nxt();
    mid(); check("go run", state_o, 1); check("go run PCBack", PCBack, 0);

    // exception wins over ERET_GO
    nxt(); eret_D = 1;
    mid();
    nxt(); eret_D = 0; exc_req = 1;
    mid(); check("go+exc state", state_o, 3); check("go+exc PCBack", PCBack, 0);
    nxt(); exc_req = 0;
    mid(); check("go+exc vec", state_o, 4);
    nxt();
    mid(); check("go+exc run", state_o, 1);

    // exception abandons ERET_WAIT
    nxt(); eret_D = 1; mtEPC_D = 1;
    mid();
    nxt(); exc_req = 1;
    mid(); check("wait+exc state", state_o, 2);
    nxt(); exc_req = 0; eret_D = 0; mtEPC_D = 0;
    mid(); check("wait+exc vec", state_o, 4); check("wait+exc PCBack", PCBack, 0);
    nxt();
    mid(); check("wait+exc run", state_o, 1);

    // reset in the middle of ERET_WAIT
    nxt(); isBranch_D = 1;
    mid(); check("pre-rst PCE", PCE, 1);
    nxt(); isBranch_D = 0; eret_D = 1; mtEPC_D = 1;
    mid(); check("pre-rst bd", isBranch, 1);
    nxt();
    mid(); check("rst-wait state", state_o, 2);
    nxt(); reset = 1;
    mid(); check("rst-wait PCBack", PCBack, 0);
    nxt(); reset = 0; eret_D = 0; mtEPC_D = 0;
    mid(); check("rst2 state", state_o, 0); check("rst2 PCE", PCE, 0);
    check("rst2 PCBack", PCBack, 0); check("rst2 isBranch", isBranch, 0);
    check("rst2 stall_cnt", stall_cnt, 0);
    nxt();
    mid(); check("rst2 boot", state_o, 0); check("rst2 boot PCBack", PCBack, 0);
    nxt();
    mid(); check("rst2 run", state_o, 1); check("rst2 run PCE", PCE, 1);
    nxt();
    mid();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
